mem_port_arbiter: RTL and testbench

Shares the single-ported unified instruction/data memory between the CPU's instruction-fetch port and load/store port. It sits between the core and the memory (or cache) and owns the memory request bus. It latches each granted request, holds it stable until the memory signals completion, and returns a one-cycle done pulse with read data to the winning requester. Conflicts are resolved round-robin, and a saturating counter records how many conflicts have occurred, for cycle-count analysis.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   WM_*        : memory write-mode encodings (WM_READ means no write)
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  localparam logic [1:0] WM_READ   = 2'b00;
  localparam logic [1:0] WM_WORD   = 2'b01;
  localparam logic [1:0] WM_DOUBLE = 2'b10;
  localparam logic [1:0] WM_RSVD   = 2'b11;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the instruction-fetch
// port (i_*) and the load/store port (d_*). Each granted request is latched
// onto the memory bus (m_*) and held until m_ready, then a one-cycle done
// pulse with read data goes back to the winner.
//   clk, reset     : clock, asynchronous active-low reset
//   i_req/i_addr   : fetch request, held until i_done; i_rdata valid with i_done
//   d_req/d_*      : load/store request, held until d_done; d_rdata valid with
//                    d_done on reads, unchanged on writes
//   m_*            : memory request bus; m_ready is a one-cycle completion
//   conflicts      : saturating count of grants made with both ports pending
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_wmode,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic [1:0]        m_wmode,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  conflicts
);

  arb_state_t state;
  logic       last_d;     // 1 when the most recent grant went to the data port
  logic       take_i;
  logic       take_d;
  logic       is_conflict;
  logic [1:0] d_mode_fwd;

  // Grant selection. In IDLE a tie goes to the port not granted last. From
  // DONE_x only the other port may be granted: x's requester may still be
  // lowering its req during the done cycle.
  always_comb begin
    take_i = 1'b0;
    take_d = 1'b0;
    case (state)
      IDLE: begin
        take_d = d_req & (~i_req | ~last_d);
        take_i = i_req & ~take_d;
      end
      DONE_I:  take_d = d_req;
      DONE_D:  take_i = i_req;
      default: ;
    endcase
  end

  // Hand-offs from DONE_x are not conflicts, only simultaneous requests in IDLE.
  assign is_conflict = (state == IDLE) & i_req & d_req;

  // The reserved write mode is treated as a plain read.
  assign d_mode_fwd = (d_wmode == WM_RSVD) ? WM_READ : d_wmode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      m_req     <= 1'b0;
      m_wmode   <= WM_READ;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      conflicts <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;

      if (is_conflict && !(&conflicts))
        conflicts <= conflicts + CNT_W'(1);

      case (state)
        BUSY_I: begin
          if (m_ready) begin
            i_rdata <= m_rdata;
            i_done  <= 1'b1;
            m_req   <= 1'b0;
            state   <= DONE_I;
          end
        end
        BUSY_D: begin
          if (m_ready) begin
            // Writes leave the last load data in place.
            if (m_wmode == WM_READ)
              d_rdata <= m_rdata;
            d_done <= 1'b1;
            m_req  <= 1'b0;
            state  <= DONE_D;
          end
        end
        default: begin  // IDLE, DONE_I, DONE_D
          if (take_d) begin
            m_req   <= 1'b1;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wmode <= d_mode_fwd;
            last_d  <= 1'b1;
            state   <= BUSY_D;
          end else if (take_i) begin
            m_req   <= 1'b1;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_wmode <= WM_READ;
            last_d  <= 1'b0;
            state   <= BUSY_I;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of lone accesses, hand
// sequences for conflicts/hand-off/saturation, async reset and spurious
// m_ready, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, m_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [1:0]    d_wmode;
  logic          i_done, d_done, m_req;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_wmode;
  logic [CW-1:0] conflicts;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wmode(d_wmode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_wmode(m_wmode), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_drd, exp_ird;
  logic        lastw;  // model: last grant went to data

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = 0; d_req = 0; m_ready = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    exp_drd = '0; exp_ird = '0; lastw = 0;
  endtask

  typedef struct {
    logic        is_d;
    logic [1:0]  wmode;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;       // cycles m_req is held before m_ready is driven
    logic [63:0] rdata;
    logic [1:0]  exp_mode;
  } vec_t;

  // One isolated access from IDLE; called at drive time (#1 after posedge).
  task automatic lone(input vec_t v);
    if (v.is_d) begin
      d_req = 1; d_addr = v.addr; d_wdata = v.wdata; d_wmode = v.wmode;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    tick;
    chk("grant m_req", m_req, 1);
    chk("grant m_addr", m_addr, v.addr);
    chk("grant m_wmode", m_wmode, v.exp_mode);
    if (v.is_d) chk("grant m_wdata", m_wdata, v.wdata);
    for (int w = 0; w < v.lat; w++) begin
      tick;
      chk("hold m_req", m_req, 1);
      chk("hold m_addr", m_addr, v.addr);
      chk("hold m_wmode", m_wmode, v.exp_mode);
      if (v.is_d) chk("hold m_wdata", m_wdata, v.wdata);
      chk("early done", {i_done, d_done}, 0);
    end
    m_ready = 1; m_rdata = v.rdata;
    tick;
    m_ready = 0; m_rdata = 64'hFFFF_0000_FFFF_0000;
    chk("done port", {i_done, d_done}, v.is_d ? 2'b01 : 2'b10);
    chk("done m_req low", m_req, 0);
    if (v.is_d) begin
      if (v.exp_mode == WM_READ) exp_drd = v.rdata;
      chk("d_rdata", d_rdata, exp_drd);
      d_req = 0;
    end else begin
      exp_ird = v.rdata;
      chk("i_rdata", i_rdata, exp_ird);
      i_req = 0;
    end
    lastw = v.is_d;
    tick;
    chk("single done pulse", {i_done, d_done}, 0);
  endtask

  // Both ports request together from IDLE; winner then hand-off to the loser.
  task automatic pair(input int n);
    logic wd;
    wd = !lastw;
    i_req = 1; i_addr = 64'h1000 + 64'(n);
    d_req = 1; d_addr = 64'h2000 + 64'(n); d_wmode = WM_READ; d_wdata = '0;
    tick;
    chk("pair winner addr", m_addr, wd ? d_addr : i_addr);
    chk("pair conflicts", conflicts, 64'(n > 3 ? 3 : n));
    m_ready = 1; m_rdata = 64'(n) * 16;
    tick;
    m_ready = 0;
    chk("pair first done", {i_done, d_done}, wd ? 2'b01 : 2'b10);
    if (wd) d_req = 0; else i_req = 0;
    tick;
    chk("handoff m_req", m_req, 1);
    chk("handoff m_addr", m_addr, wd ? i_addr : d_addr);
    chk("handoff conflicts", conflicts, 64'(n > 3 ? 3 : n));
    m_ready = 1; m_rdata = 64'(n) * 16 + 1;
    tick;
    m_ready = 0;
    chk("pair second done", {i_done, d_done}, wd ? 2'b10 : 2'b01);
    i_req = 0; d_req = 0;
    lastw = !wd;
    tick;
  endtask

  // Randomized traffic checked against transaction-level rules.
  task automatic random_phase(input int ncyc);
    logic        p_mreq, p_idone, p_ddone, pdone, eg, wd, act_d, act_rd;
    logic        i_linger, d_linger;
    logic [63:0] p_maddr, p_mwdata;
    logic [1:0]  p_mwmode, em;
    int          mwait, conf;
    p_mreq = 0; p_idone = 0; p_ddone = 0; p_maddr = '0; p_mwdata = '0; p_mwmode = '0;
    act_d = 0; act_rd = 0; mwait = 0; conf = 0; i_linger = 0; d_linger = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick;
      // inputs still hold the values seen at the edge just taken
      chk("rnd i_done", i_done, p_mreq && m_ready && !act_d);
      chk("rnd d_done", d_done, p_mreq && m_ready && act_d);
      if (p_mreq && m_ready && !act_d) begin
        exp_ird = m_rdata;
        chk("rnd i_rdata", i_rdata, exp_ird);
      end
      if (p_mreq && m_ready && act_d) begin
        if (act_rd) exp_drd = m_rdata;
        chk("rnd d_rdata", d_rdata, exp_drd);
      end
      if (p_mreq) begin
        if (m_ready) chk("rnd m_req drop", m_req, 0);
        else begin
          chk("rnd m_req held", m_req, 1);
          chk("rnd m_addr held", m_addr, p_maddr);
          chk("rnd m_wmode held", m_wmode, p_mwmode);
          chk("rnd m_wdata held", m_wdata, p_mwdata);
        end
      end else begin
        pdone = p_idone | p_ddone;
        eg = pdone ? (p_idone ? d_req : i_req) : (i_req | d_req);
        chk("rnd grant", m_req, eg);
        if (eg) begin
          if (pdone) wd = p_idone;
          else if (i_req && d_req) begin
            wd = !lastw;
            if (conf < 3) conf++;
          end else wd = d_req;
          em = wd ? ((d_wmode == WM_RSVD) ? WM_READ : d_wmode) : WM_READ;
          chk("rnd grant addr", m_addr, wd ? d_addr : i_addr);
          chk("rnd grant wmode", m_wmode, em);
          if (wd) chk("rnd grant wdata", m_wdata, d_wdata);
          act_d = wd; act_rd = (em == WM_READ); lastw = wd;
          mwait = $urandom_range(0, 2);
        end
      end
      chk("rnd conflicts", conflicts, 64'(conf));
      p_mreq = m_req; p_idone = i_done; p_ddone = d_done;
      p_maddr = m_addr; p_mwdata = m_wdata; p_mwmode = m_wmode;
      // memory responder
      if (m_req) begin
        if (mwait == 0) begin
          m_ready = 1; m_rdata = {$urandom, $urandom};
        end else begin
          m_ready = 0; mwait--;
        end
      end else begin
        m_ready = ($urandom % 6 == 0);
        m_rdata = {$urandom, $urandom};
      end
      // requesters: may keep req up through their done cycle, then drop it
      if (i_linger) begin i_req = 0; i_linger = 0; end
      else if (i_done) begin if ($urandom % 2 == 0) i_req = 0; else i_linger = 1; end
      else if (!i_req && $urandom % 3 == 0) begin
        i_req = 1; i_addr = {$urandom, $urandom}; i_addr[63] = 1'b0;
      end
      if (d_linger) begin d_req = 0; d_linger = 0; end
      else if (d_done) begin if ($urandom % 2 == 0) d_req = 0; else d_linger = 1; end
      else if (!d_req && $urandom % 3 == 0) begin
        d_req = 1; d_addr = {$urandom, $urandom}; d_addr[63] = 1'b1;
        d_wdata = {$urandom, $urandom}; d_wmode = 2'($urandom_range(0, 3));
      end
    end
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    rst_n = 0; i_req = 0; d_req = 0; m_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmode = '0; m_rdata = '0;
    exp_drd = '0; exp_ird = '0; lastw = 0;
    #12;
    chk("reset m_req", m_req, 0);
    chk("reset m_addr", m_addr, 0);
    chk("reset m_wdata", m_wdata, 0);
    chk("reset m_wmode", m_wmode, 0);
    chk("reset dones", {i_done, d_done}, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset conflicts", conflicts, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    //         is_d wmode      addr    wdata  lat rdata          exp_mode
    vecs[0] = '{0, WM_READ,   64'h40,  64'h0, 1, 64'h20020005,  WM_READ};
    vecs[1] = '{1, WM_READ,   64'h200, 64'h0, 2, 64'h11112222,  WM_READ};
    vecs[2] = '{1, WM_DOUBLE, 64'd100, 64'd7, 3, 64'hBAD,       WM_DOUBLE};
    vecs[3] = '{1, WM_WORD,   64'h208, 64'h55, 0, 64'hBAD2,     WM_WORD};
    vecs[4] = '{1, WM_RSVD,   64'h300, 64'h9, 1, 64'hABCD,      WM_READ};
    vecs[5] = '{0, WM_READ,   64'h44,  64'h0, 0, 64'h77,        WM_READ};
    for (int k = 0; k < 6; k++) lone(vecs[k]);

    // spurious m_ready while idle
    m_ready = 1; m_rdata = 64'h1234;
    tick;
    m_ready = 0;
    chk("spurious m_req", m_req, 0);
    chk("spurious done", {i_done, d_done}, 0);
    tick;
    chk("spurious done late", {i_done, d_done}, 0);
    chk("spurious i_rdata", i_rdata, exp_ird);

    // conflicts, hand-off and saturation from a fresh reset
    do_reset;
    pair(1);
    // a lone load makes data the last grant, so fetch wins the next tie
    v = '{1, WM_READ, 64'h600, 64'h0, 1, 64'h66, WM_READ};
    lone(v);
    for (int n = 2; n <= 5; n++) pair(n);

    // async reset with a load in flight and m_ready pending
    d_req = 1; d_addr = 64'h500; d_wmode = WM_READ;
    tick;
    chk("rst busy m_req", m_req, 1);
    tick;
    m_ready = 1; m_rdata = 64'h99;
    #1 rst_n = 0;
    #1 chk("rst drops m_req", m_req, 0);
    @(posedge clk);
    #1;
    chk("rst no d_done", d_done, 0);
    m_ready = 0; d_req = 0; rst_n = 1;
    exp_drd = '0; exp_ird = '0; lastw = 0;
    tick;
    chk("rst no d_done late", d_done, 0);
    chk("rst conflicts", conflicts, 0);
    chk("rst d_rdata", d_rdata, 0);
    v = '{0, WM_READ, 64'h80, 64'h0, 1, 64'h5A5A, WM_READ};
    lone(v);

    do_reset;
    random_phase(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
